// File: rtl/tpu_pkg.sv
// Shared types and arithmetic helpers for the accumulator row buffer.
// The widths defined here are only defaults. Each module carries its own parameters.
package tpu_pkg;

    localparam int TPU_IN_W  = 16;
    localparam int TPU_ACC_W = 32;
    localparam int TPU_DEPTH = 4;
    localparam int SAT_W     = 64;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } accbuf_state_t;

    typedef struct packed {
        logic [SAT_W-1:0] sum;
        logic             sat;
    } sat_res_t;

    // Both operands arrive already sign-extended to SAT_W.
    // acc_w selects the saturation bounds, so one helper serves every accumulator width.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] addend,
        input int unsigned             acc_w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                res;
        sum = acc + addend;
        hi  = (64'sd1 <<< (acc_w - 32'd1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            res.sum = hi;
            res.sat = 1'b1;
        end else if (sum < lo) begin
            res.sum = lo;
            res.sat = 1'b1;
        end else begin
            res.sum = sum;
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Per-column datapath. It either sign-extends the input into the accumulator width,
// or adds the input onto the stored value with saturation.
module acc_sat_add
    import tpu_pkg::*;
#(
    parameter int IN_W  = TPU_IN_W,
    parameter int ACC_W = TPU_ACC_W
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  in_i,
    input  logic             acc_mode,
    output logic [ACC_W-1:0] sum_o,
    output logic             sat_o
);

    logic [SAT_W-1:0]       acc_ext_s;
    logic [SAT_W-1:0]       in_ext_s;
    sat_res_t               res_s;
    logic [SAT_W-ACC_W-1:0] unused_hi_s;

    assign acc_ext_s   = SAT_W'($signed(acc_i));
    assign in_ext_s    = SAT_W'($signed(in_i));
    assign unused_hi_s = res_s.sum[SAT_W-1:ACC_W];

    // An overwrite always fits the accumulator, so only the accumulate path can saturate.
    always_comb begin
        res_s = sat_add(acc_ext_s, in_ext_s, 32'(ACC_W));
        if (acc_mode) begin
            sum_o = res_s.sum[ACC_W-1:0];
            sat_o = res_s.sat;
        end else begin
            sum_o = in_ext_s[ACC_W-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/accumulator_buffer.sv
// Row buffer after column alignment. It writes or accumulates 2-column rows into a small
// register file, then streams the stored rows out over valid/ready on request.
module accumulator_buffer
    import tpu_pkg::*;
#(
    parameter int IN_W  = TPU_IN_W,
    parameter int ACC_W = TPU_ACC_W,
    parameter int DEPTH = TPU_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_col0,
    input  logic [IN_W-1:0]  in_col1,
    input  logic             acc_mode,
    input  logic             drain_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_col0,
    output logic [ACC_W-1:0] out_col1,
    output logic             out_last,
    output logic             busy,
    output logic             drain_done,
    output logic             overflow_err,
    output logic             sat_flag
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    accbuf_state_t    state_q, state_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ACC_W-1:0] col0_q [DEPTH];
    logic [ACC_W-1:0] col0_d [DEPTH];
    logic [ACC_W-1:0] col1_q [DEPTH];
    logic [ACC_W-1:0] col1_d [DEPTH];
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_col0_q, out_col0_d;
    logic [ACC_W-1:0] out_col1_q, out_col1_d;
    logic             out_last_q, out_last_d;
    logic             drain_done_q, drain_done_d;
    logic             overflow_err_q, overflow_err_d;
    logic             sat_flag_q, sat_flag_d;

    logic [PTR_W-1:0] wr_idx_s;
    logic [ACC_W-1:0] acc0_s, acc1_s;
    logic [ACC_W-1:0] sum0_s, sum1_s;
    logic             sat0_s, sat1_s;
    logic             load_s;
    logic [PTR_W-1:0] load_idx_s;

    assign wr_idx_s = wr_ptr_q[PTR_W-1:0];
    assign acc0_s   = col0_q[wr_idx_s];
    assign acc1_s   = col1_q[wr_idx_s];

    acc_sat_add #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add_col0 (
        .acc_i    (acc0_s),
        .in_i     (in_col0),
        .acc_mode (acc_mode),
        .sum_o    (sum0_s),
        .sat_o    (sat0_s)
    );

    acc_sat_add #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add_col1 (
        .acc_i    (acc1_s),
        .in_i     (in_col1),
        .acc_mode (acc_mode),
        .sum_o    (sum1_s),
        .sat_o    (sat1_s)
    );

    // Next-state logic. FILL captures and accumulates rows; DRAIN streams them out one per handshake.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        row_cnt_d      = row_cnt_q;
        rd_ptr_d       = rd_ptr_q;
        col0_d         = col0_q;
        col1_d         = col1_q;
        out_valid_d    = out_valid_q;
        out_col0_d     = out_col0_q;
        out_col1_d     = out_col1_q;
        out_last_d     = out_last_q;
        drain_done_d   = 1'b0;
        overflow_err_d = overflow_err_q;
        sat_flag_d     = sat_flag_q;
        load_s         = 1'b0;
        load_idx_s     = '0;
        case (state_q)
            FILL: begin
                if (!in_valid) begin
                    wr_ptr_d = '0;
                end else if (wr_ptr_q == FULL_CNT) begin
                    overflow_err_d = 1'b1;
                end else begin
                    col0_d[wr_idx_s] = sum0_s;
                    col1_d[wr_idx_s] = sum1_s;
                    sat_flag_d       = sat_flag_q | sat0_s | sat1_s;
                    wr_ptr_d         = wr_ptr_q + CNT_W'(1);
                    if (row_cnt_q < wr_ptr_d) begin
                        row_cnt_d = wr_ptr_d;
                    end else begin
                        row_cnt_d = row_cnt_q;
                    end
                end
                // Uses the post-write row count and data, so a same-cycle write is drained too.
                if (!drain_req) begin
                    state_d = FILL;
                end else if (row_cnt_d == '0) begin
                    drain_done_d = 1'b1;
                end else begin
                    state_d     = DRAIN;
                    load_s      = 1'b1;
                    load_idx_s  = '0;
                    rd_ptr_d    = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = (row_cnt_d == CNT_W'(1));
                end
            end
            DRAIN: begin
                overflow_err_d = overflow_err_q | in_valid;
                if (!(out_valid_q && out_ready)) begin
                    state_d = DRAIN;
                end else if (out_last_q) begin
                    state_d      = FILL;
                    out_valid_d  = 1'b0;
                    out_last_d   = 1'b0;
                    out_col0_d   = '0;
                    out_col1_d   = '0;
                    drain_done_d = 1'b1;
                    row_cnt_d    = '0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                end else begin
                    load_s     = 1'b1;
                    load_idx_s = rd_ptr_q + PTR_W'(1);
                    rd_ptr_d   = load_idx_s;
                    out_last_d = (CNT_W'(load_idx_s) == row_cnt_q - CNT_W'(1));
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        // The row moving into the output register leaves a cleared slot behind.
        if (load_s) begin
            out_col0_d         = col0_d[load_idx_s];
            out_col1_d         = col1_d[load_idx_s];
            col0_d[load_idx_s] = '0;
            col1_d[load_idx_s] = '0;
        end
    end

    // State, register file and output registers. The reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= FILL;
            wr_ptr_q       <= '0;
            row_cnt_q      <= '0;
            rd_ptr_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                col0_q[i] <= '0;
                col1_q[i] <= '0;
            end
            out_valid_q    <= 1'b0;
            out_col0_q     <= '0;
            out_col1_q     <= '0;
            out_last_q     <= 1'b0;
            drain_done_q   <= 1'b0;
            overflow_err_q <= 1'b0;
            sat_flag_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            row_cnt_q      <= row_cnt_d;
            rd_ptr_q       <= rd_ptr_d;
            col0_q         <= col0_d;
            col1_q         <= col1_d;
            out_valid_q    <= out_valid_d;
            out_col0_q     <= out_col0_d;
            out_col1_q     <= out_col1_d;
            out_last_q     <= out_last_d;
            drain_done_q   <= drain_done_d;
            overflow_err_q <= overflow_err_d;
            sat_flag_q     <= sat_flag_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_col0     = out_col0_q;
    assign out_col1     = out_col1_q;
    assign out_last     = out_last_q;
    assign busy         = (state_q == DRAIN);
    assign drain_done   = drain_done_q;
    assign overflow_err = overflow_err_q;
    assign sat_flag     = sat_flag_q;

endmodule
